// File: rtl/imem_if.sv
// Handshake bundle between the IMEM controller, the host load port and the NoC router.
// The slave modport is the controller's view; master is the host/router side.
interface imem_if #(
   parameter int PKT_W  = 33,
   parameter int TS_W   = 1,
   parameter int ADDR_W = 10
);
   logic              load_start;
   logic              ld_valid;
   logic              ld_ready;
   logic [TS_W-1:0]   ld_ts;
   logic [ADDR_W-1:0] ld_addr;
   logic              ld_bit;
   logic              load_done;
   logic              rx_valid;
   logic              rx_ready;
   logic [PKT_W-1:0]  rx_pkt;
   logic              tx_valid;
   logic              tx_ready;
   logic [PKT_W-1:0]  tx_pkt;

   modport slave (
      input  load_start, ld_valid, ld_ts, ld_addr, ld_bit, load_done,
      input  rx_valid, rx_pkt, tx_ready,
      output ld_ready, rx_ready, tx_valid, tx_pkt
   );

   modport master (
      output load_start, ld_valid, ld_ts, ld_addr, ld_bit, load_done,
      output rx_valid, rx_pkt, tx_ready,
      input  ld_ready, rx_ready, tx_valid, tx_pkt
   );
endinterface

// File: rtl/imem_ctrl.sv
// Input-feature-map memory controller: loads spike bits per timestep from the host,
// then serves 25-bit ifmap rows to PEs over the NoC until every timestep has ended.
module imem_ctrl #(
   parameter int         DEPTH_I   = 25,
   parameter int         TS_NUM    = 2,
   parameter int         PKT_W     = 33,
   parameter int         TS_W      = (TS_NUM > 1) ? $clog2(TS_NUM) : 1,
   parameter logic [3:0] CTRL_NODE = 4'd11,
   parameter logic [3:0] OP_WDONE  = 4'd0,
   parameter logic [3:0] OP_TSEND  = 4'd15,
   parameter logic [3:0] OP_IFROW  = 4'd1
) (
   input  logic            clk,
   input  logic            rst_n,
   imem_if.slave           bus,
   output logic [TS_W-1:0] cur_ts,
   output logic            done,
   output logic            err
);

   localparam int         RC_W   = $clog2(DEPTH_I);
   localparam logic [RC_W-1:0] LAST_RC = RC_W'(DEPTH_I - 1);
   localparam logic [TS_W-1:0] LAST_TS = TS_W'(TS_NUM - 1);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT, SERVE, RESP, DONE} state_t;

   state_t              state, next_state;
   logic [DEPTH_I-1:0]  mem [TS_NUM][DEPTH_I];
   logic [RC_W-1:0]     row_cnt, col_cnt;
   logic [TS_W-1:0]     ts_cnt;
   logic [9:0]          pix_cnt;
   logic                full;
   logic [PKT_W-1:0]    tx_pkt_q;

   logic [3:0]          rx_addr, rx_op;
   logic [RC_W-1:0]     rx_row, rd_idx;
   logic                is_ctrl, row_bad, ld_acc, rx_acc, last_pos, row_end;
   logic [DEPTH_I-1:0]  rd_row;

   assign rx_addr  = bus.rx_pkt[PKT_W-1 -: 4];
   assign rx_op    = bus.rx_pkt[PKT_W-5 -: 4];
   assign rx_row   = bus.rx_pkt[RC_W-1:0];
   assign is_ctrl  = (rx_addr == CTRL_NODE);
   assign row_bad  = (rx_row > LAST_RC);
   assign rd_idx   = row_bad ? '0 : rx_row;
   assign rd_row   = row_bad ? '0 : mem[cur_ts][rd_idx];
   assign ld_acc   = bus.ld_valid && bus.ld_ready;
   assign rx_acc   = bus.rx_valid && bus.rx_ready;
   assign row_end  = (row_cnt == LAST_RC) && (col_cnt == LAST_RC);
   assign last_pos = row_end && (ts_cnt == LAST_TS);
   assign bus.tx_pkt = tx_pkt_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state and handshake outputs; RESP blocks new requests so only one is outstanding
   always_comb begin
      next_state   = state;
      bus.ld_ready = 1'b0;
      bus.rx_ready = 1'b0;
      bus.tx_valid = 1'b0;
      done         = 1'b0;
      case (state)
         IDLE:  if (bus.load_start) next_state = LOAD;
         LOAD: begin
            bus.ld_ready = 1'b1;
            if (bus.load_done) next_state = WAIT;
         end
         WAIT: begin
            bus.rx_ready = 1'b1;
            if (bus.rx_valid && is_ctrl && rx_op == OP_WDONE) next_state = SERVE;
         end
         SERVE: begin
            bus.rx_ready = 1'b1;
            if (bus.rx_valid) begin
               if (!is_ctrl) next_state = RESP;
               else if (rx_op == OP_TSEND && cur_ts == LAST_TS) next_state = DONE;
            end
         end
         RESP: begin
            bus.tx_valid = 1'b1;
            if (bus.tx_ready) next_state = SERVE;
         end
         DONE:    done = 1'b1;
         default: next_state = IDLE;
      endcase
   end

   // Write pointer, timestep, response register and sticky error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_cnt  <= '0;
         col_cnt  <= '0;
         ts_cnt   <= '0;
         pix_cnt  <= '0;
         full     <= 1'b0;
         cur_ts   <= '0;
         tx_pkt_q <= '0;
         err      <= 1'b0;
      end else begin
         if (state == IDLE && bus.load_start) begin
            row_cnt <= '0;
            col_cnt <= '0;
            ts_cnt  <= '0;
            pix_cnt <= '0;
            full    <= 1'b0;
         end
         if (ld_acc) begin
            if (full) begin
               err <= 1'b1;
            end else begin
               if (bus.ld_addr != pix_cnt || bus.ld_ts != ts_cnt) err <= 1'b1;
               if (last_pos) begin
                  full <= 1'b1;
               end else if (row_end) begin
                  row_cnt <= '0;
                  col_cnt <= '0;
                  pix_cnt <= '0;
                  ts_cnt  <= ts_cnt + 1'b1;
               end else begin
                  pix_cnt <= pix_cnt + 10'd1;
                  if (col_cnt == LAST_RC) begin
                     col_cnt <= '0;
                     row_cnt <= row_cnt + 1'b1;
                  end else begin
                     col_cnt <= col_cnt + 1'b1;
                  end
               end
            end
         end
         // A beat arriving alongside load_done counts toward a complete load
         if (state == LOAD && bus.load_done && !(full || (ld_acc && last_pos))) err <= 1'b1;
         if (state == WAIT && rx_acc) begin
            if (is_ctrl && rx_op == OP_WDONE) cur_ts <= '0;
            else                              err    <= 1'b1;
         end
         if (state == SERVE && rx_acc) begin
            if (!is_ctrl) begin
               tx_pkt_q <= {rx_addr, OP_IFROW, rd_row};
               if (row_bad) err <= 1'b1;
            end else if (rx_op == OP_TSEND && cur_ts != LAST_TS) begin
               cur_ts <= cur_ts + 1'b1;
            end
         end
      end
   end

   // Memory array has no reset; contents are only meaningful after a load
   always_ff @(posedge clk) begin
      if (ld_acc && !full) mem[ts_cnt][row_cnt][col_cnt] <= bus.ld_bit;
   end

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed self-checking bench for imem_ctrl: load, serve, timestep advance,
// backpressure, error cases and back-to-back throughput.
module tb_imem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [0:0]  cur_ts;
   logic        done, err;
   int          checks = 0;
   int          errors = 0;
   logic [32:0] resp;

   imem_if #(.PKT_W(33), .TS_W(1), .ADDR_W(10)) bus ();

   imem_ctrl dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .cur_ts (cur_ts),
      .done   (done),
      .err    (err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [32:0] mkPkt(input int addr, input int op, input int data);
      logic [3:0]  a = 4'(addr);
      logic [3:0]  o = 4'(op);
      logic [24:0] d = 25'(data);
      return {a, o, d};
   endfunction

   // Timestep 0 holds a checkerboard (r+c)&1, timestep 1 is all ones
   function automatic logic [24:0] rowModel(input int ts, input int row);
      logic [24:0] v = '0;
      if (row >= 25) return v;
      for (int c = 0; c < 25; c++) v[c] = (ts == 0) ? 1'((row + c) & 1) : 1'b1;
      return v;
   endfunction

   task automatic applyReset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.load_start = 0; bus.ld_valid = 0; bus.ld_ts = 0; bus.ld_addr = 0;
      bus.ld_bit = 0; bus.load_done = 0; bus.rx_valid = 0; bus.rx_pkt = '0;
      bus.tx_ready = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulseLoadStart();
      bus.load_start = 1'b1;
      @(negedge clk);
      bus.load_start = 1'b0;
   endtask

   task automatic loadBeat(input int ts, input int addr, input logic b, input logic fin);
      bus.ld_valid = 1'b1; bus.ld_ts = 1'(ts); bus.ld_addr = 10'(addr);
      bus.ld_bit = b; bus.load_done = fin;
      @(negedge clk);
      bus.ld_valid = 1'b0; bus.load_done = 1'b0;
   endtask

   task automatic loadAll();
      for (int ts = 0; ts < 2; ts++)
         for (int p = 0; p < 625; p++)
            loadBeat(ts, p, (ts == 0) ? 1'(((p / 25) + (p % 25)) & 1) : 1'b1,
                     (ts == 1 && p == 624));
   endtask

   // Present one packet and hold it until the controller accepts it
   task automatic applyStimulus(input logic [32:0] pkt);
      bit ok = 0;
      bus.rx_valid = 1'b1;
      bus.rx_pkt = pkt;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (bus.rx_ready) ok = 1;
         @(negedge clk);
      end
      bus.rx_valid = 1'b0;
      if (!ok) checkOutput("rx_accept_timeout", 0, 1);
   endtask

   task automatic takeResp(output logic [32:0] pkt);
      bit ok = 0;
      pkt = '0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (bus.tx_valid) begin ok = 1; pkt = bus.tx_pkt; end
         else @(negedge clk);
      end
      if (!ok) checkOutput("tx_valid_timeout", 0, 1);
      bus.tx_ready = 1'b1;
      @(negedge clk);
      bus.tx_ready = 1'b0;
   endtask

   initial begin
      int cycles, sent, got;
      bit acc;
      logic [32:0] exp_a, exp_b;

      // Reset asserted mid-load clears outputs immediately
      applyReset();
      pulseLoadStart();
      for (int p = 0; p < 5; p++) loadBeat(0, p, 1'b1, 1'b0);
      checkOutput("t1_ld_ready_in_load", bus.ld_ready, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t1_ld_ready_rst", bus.ld_ready, 0);
      checkOutput("t1_outs_rst", {bus.rx_ready, bus.tx_valid, done, err, cur_ts}, 0);
      checkOutput("t1_tx_pkt_rst", bus.tx_pkt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("t1_idle_ready", {bus.ld_ready, bus.rx_ready}, 0);

      // Full load with load_done on the final beat, then weights-done
      pulseLoadStart();
      loadAll();
      checkOutput("t2_err_after_load", err, 0);
      checkOutput("t2_wait_ready", {bus.ld_ready, bus.rx_ready}, 2'b01);
      applyStimulus(mkPkt(11, 0, 0));
      checkOutput("t2_serve_cur_ts", cur_ts, 0);
      checkOutput("t2_serve_rx_ready", bus.rx_ready, 1);

      // (3+c)&1 with bit c = column c puts row 3's ones on even columns
      applyStimulus(mkPkt(5, 3, 3));
      checkOutput("t2_tx_valid_n1", bus.tx_valid, 1);
      checkOutput("t2_rx_ready_resp", bus.rx_ready, 0);
      takeResp(resp);
      checkOutput("t2_row3", resp, {4'd5, 4'd1, 25'h1555555});
      checkOutput("t2_tx_valid_after", bus.tx_valid, 0);
      applyStimulus(mkPkt(5, 0, 2));
      takeResp(resp);
      checkOutput("t2_row2", resp, {4'd5, 4'd1, 25'h0AAAAAA});
      applyStimulus(mkPkt(7, 0, 24));
      takeResp(resp);
      checkOutput("t2_row24", resp, {4'd7, 4'd1, rowModel(0, 24)});
      applyStimulus(mkPkt(11, 0, 0));
      checkOutput("t2_wdone_ignored", {err, bus.rx_ready, cur_ts}, 2'b01 << 1);

      // Backpressure: response held, second request waits
      exp_a = {4'd2, 4'd1, rowModel(0, 4)};
      exp_b = {4'd3, 4'd1, rowModel(0, 5)};
      applyStimulus(mkPkt(2, 0, 4));
      bus.rx_valid = 1'b1;
      bus.rx_pkt = mkPkt(3, 0, 5);
      for (int i = 0; i < 10; i++) begin
         checkOutput("t4_hold_pkt", bus.tx_pkt, exp_a);
         checkOutput("t4_hold_valid_ready", {bus.tx_valid, bus.rx_ready}, 2'b10);
         @(negedge clk);
      end
      bus.tx_ready = 1'b1;
      @(negedge clk);
      checkOutput("t4_serve_again", bus.rx_ready, 1);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      checkOutput("t4_second_pkt", bus.tx_pkt, exp_b);
      checkOutput("t4_second_valid", bus.tx_valid, 1);
      @(negedge clk);
      bus.tx_ready = 1'b0;

      // Back-to-back requests with the router always ready
      bus.tx_ready = 1'b1;
      cycles = 0; sent = 0; got = 0;
      bus.rx_valid = 1'b1;
      bus.rx_pkt = mkPkt(0, 0, 0);
      while (got < 20 && cycles < 200) begin
         if (bus.tx_valid) begin
            checkOutput($sformatf("t6_resp%0d", got), bus.tx_pkt,
                        {4'(got % 10), 4'd1, rowModel(0, (got * 7) % 25)});
            got++;
         end
         acc = bus.rx_valid && bus.rx_ready;
         @(negedge clk);
         cycles++;
         if (acc) begin
            sent++;
            if (sent < 20) bus.rx_pkt = mkPkt(sent % 10, 0, (sent * 7) % 25);
            else           bus.rx_valid = 1'b0;
         end
      end
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b0;
      checkOutput("t6_cycles", cycles, 40);

      // Out-of-range row returns zero data and flags err
      checkOutput("t5_err_before", err, 0);
      applyStimulus(mkPkt(6, 0, 30));
      takeResp(resp);
      checkOutput("t5_row30", resp, {4'd6, 4'd1, 25'h0});
      checkOutput("t5_row30_err", err, 1);

      // Timestep advance, then final end-of-timestep
      applyStimulus(mkPkt(11, 15, 0));
      checkOutput("t3_cur_ts", cur_ts, 1);
      checkOutput("t3_not_done", done, 0);
      applyStimulus(mkPkt(9, 0, 0));
      takeResp(resp);
      checkOutput("t3_ts1_row0", resp, {4'd9, 4'd1, 25'h1FFFFFF});
      applyStimulus(mkPkt(11, 15, 0));
      checkOutput("t3_done", {done, bus.rx_ready, bus.ld_ready}, 3'b100);
      pulseLoadStart();
      checkOutput("t3_done_sticky", {done, bus.ld_ready}, 2'b10);

      // Address skip during load
      applyReset();
      pulseLoadStart();
      loadBeat(0, 0, 1'b0, 1'b0);
      loadBeat(0, 1, 1'b0, 1'b0);
      checkOutput("t5_skip_err_before", err, 0);
      loadBeat(0, 3, 1'b0, 1'b0);
      checkOutput("t5_skip_err", err, 1);

      // Short load: load_done after 100 beats
      applyReset();
      pulseLoadStart();
      for (int p = 0; p < 100; p++) loadBeat(0, p, 1'b0, 1'b0);
      checkOutput("t5_short_err_before", err, 0);
      bus.load_done = 1'b1;
      @(negedge clk);
      bus.load_done = 1'b0;
      checkOutput("t5_short_err", err, 1);
      checkOutput("t5_short_wait", {bus.ld_ready, bus.rx_ready}, 2'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout got 0 expected 1");
      $fatal(1, "[TB] timeout");
   end

endmodule
